// File: rtl/vga_timing_pkg.sv
// Purpose: shared constants and helpers for the VGA raster timing generator.
//  - Default 640x480@60 mode constants (VGA_*).
//  - Small simulation mode constants (SIM_*): 14-clk lines, 8-line frames.
//  - vga_total(): total period of one axis from its four segment widths.
package vga_timing_pkg;

    // 640x480@60 with a 25.175 MHz pixel clock
    localparam int unsigned VGA_CW       = 10;
    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FRONT  = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BACK   = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FRONT  = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BACK   = 33;
    localparam logic        VGA_H_POL    = 1'b0;
    localparam logic        VGA_V_POL    = 1'b0;

    // Tiny mode for fast simulation
    localparam int unsigned SIM_H_ACTIVE = 8;
    localparam int unsigned SIM_H_FRONT  = 2;
    localparam int unsigned SIM_H_SYNC   = 3;
    localparam int unsigned SIM_H_BACK   = 1;
    localparam int unsigned SIM_V_ACTIVE = 4;
    localparam int unsigned SIM_V_FRONT  = 1;
    localparam int unsigned SIM_V_SYNC   = 2;
    localparam int unsigned SIM_V_BACK   = 1;
    localparam logic        SIM_H_POL    = 1'b1;
    localparam logic        SIM_V_POL    = 1'b1;

    // Total clocks (or lines) per axis period
    function automatic int unsigned vga_total(input int unsigned active,
                                              input int unsigned front,
                                              input int unsigned sync,
                                              input int unsigned back);
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Purpose: one raster axis counter, counts 0..TOTAL-1 on inc and wraps to 0.
// Ports:
//  clk   in   1   clock
//  rst   in   1   asynchronous active-high reset (count -> 0)
//  inc   in   1   advance the count on this edge
//  cnt   out  CW  current count
//  wrap  out  1   combinational: inc is high and the count is at TOTAL-1
module vga_axis_counter #(
    parameter int unsigned TOTAL = 800,
    parameter int unsigned CW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    logic [CW-1:0] r_cnt;

    assign wrap = inc && (r_cnt == LAST);
    assign cnt  = r_cnt;

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= wrap ? '0 : r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Purpose: parametrised VGA raster timing generator. Outputs are registered from
//  the decode of the current h/v counters, so they lag the counters by one clk
//  and stay mutually aligned.
// Optional feature macro: VGA_TIMING_PIX_CE_EN adds a pixel clock enable (pix_ce);
//  without it the counters advance every clk.
// Ports:
//  clk          in   1   pixel clock
//  rst          in   1   asynchronous active-high reset
//  pix_ce       in   1   pixel clock enable (VGA_TIMING_PIX_CE_EN only)
//  hsync        out  1   horizontal sync, active level H_POL
//  vsync        out  1   vertical sync, active level V_POL
//  de           out  1   (x,y) is a visible pixel
//  x            out  CW  horizontal position of the pixel described this cycle
//  y            out  CW  vertical position of that pixel
//  line_start   out  1   one-clk pulse, pixel has x==0
//  frame_start  out  1   one-clk pulse, pixel has x==0 && y==0
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CW       = VGA_CW,
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FRONT  = VGA_H_FRONT,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BACK   = VGA_H_BACK,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FRONT  = VGA_V_FRONT,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BACK   = VGA_V_BACK,
    parameter logic        H_POL    = VGA_H_POL,
    parameter logic        V_POL    = VGA_V_POL
) (
    input  logic          clk,
    input  logic          rst,
`ifdef VGA_TIMING_PIX_CE_EN
    input  logic          pix_ce,
`endif
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL = vga_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = vga_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

    // Segment boundaries; all lie below the axis total, so they fit in CW bits
    localparam logic [CW-1:0] H_ACT_END = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SYN_BEG = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] H_SYN_END = CW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] V_ACT_END = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SYN_BEG = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] V_SYN_END = CW'(V_ACTIVE + V_FRONT + V_SYNC);

    // Reject modes with an empty segment or a period the counters cannot hold
    generate
        if (H_ACTIVE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
            V_ACTIVE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_err_zero
            $error("vga_timing_gen: every porch/sync/active width must be non-zero");
        end
        if (CW == 0 || CW > 30 ||
            H_TOTAL > (32'd1 << CW) || V_TOTAL > (32'd1 << CW)) begin : g_err_width
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 2**CW counter range");
        end
    endgenerate

    logic          w_ce;
    logic [CW-1:0] w_h_cnt;
    logic [CW-1:0] w_v_cnt;
    logic          w_h_wrap;
    logic          w_unused_v_wrap;
    logic          w_de;
    logic          w_hs_act;
    logic          w_vs_act;
    logic          w_line;
    logic          w_frame;

    logic          r_hsync;
    logic          r_vsync;
    logic          r_de;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic          r_line_start;
    logic          r_frame_start;

`ifdef VGA_TIMING_PIX_CE_EN
    assign w_ce = pix_ce;
`else
    assign w_ce = 1'b1;
`endif

    vga_axis_counter #(
        .TOTAL (H_TOTAL),
        .CW    (CW)
    ) u_h_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_ce),
        .cnt  (w_h_cnt),
        .wrap (w_h_wrap)
    );

    // Line counter steps once per completed line
    vga_axis_counter #(
        .TOTAL (V_TOTAL),
        .CW    (CW)
    ) u_v_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (w_h_wrap),
        .cnt  (w_v_cnt),
        .wrap (w_unused_v_wrap)
    );

    // Position decode of the current counters
    always_comb begin
        w_de     = (w_h_cnt < H_ACT_END) && (w_v_cnt < V_ACT_END);
        w_hs_act = (w_h_cnt >= H_SYN_BEG) && (w_h_cnt < H_SYN_END);
        w_vs_act = (w_v_cnt >= V_SYN_BEG) && (w_v_cnt < V_SYN_END);
        w_line   = (w_h_cnt == '0);
        w_frame  = w_line && (w_v_cnt == '0);
    end

    // Output registers; strobes last one clk even when the pixel rate is divided
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync       <= ~H_POL;
            r_vsync       <= ~V_POL;
            r_de          <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_ce && w_line;
            r_frame_start <= w_ce && w_frame;
            if (w_ce) begin
                r_hsync <= w_hs_act ? H_POL : ~H_POL;
                r_vsync <= w_vs_act ? V_POL : ~V_POL;
                r_de    <= w_de;
                r_x     <= w_h_cnt;
                r_y     <= w_v_cnt;
            end
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign de          = r_de;
    assign x           = r_x;
    assign y           = r_y;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen in the small simulation mode.
// A reference model tracks the pixel index within the frame and derives x/y,
// syncs and strobes arithmetically; a monitor compares the DUT each cycle.
module tb_vga_timing_gen;
    import vga_timing_pkg::*;

    localparam int unsigned CW    = 10;
    localparam int unsigned HA    = SIM_H_ACTIVE;
    localparam int unsigned HF    = SIM_H_FRONT;
    localparam int unsigned HS    = SIM_H_SYNC;
    localparam int unsigned HB    = SIM_H_BACK;
    localparam int unsigned VA    = SIM_V_ACTIVE;
    localparam int unsigned VF    = SIM_V_FRONT;
    localparam int unsigned VS    = SIM_V_SYNC;
    localparam int unsigned VB    = SIM_V_BACK;
    localparam int unsigned HT    = HA + HF + HS + HB;
    localparam int unsigned VT    = VA + VF + VS + VB;
    localparam int unsigned FRAME = HT * VT;
    localparam logic        HP    = SIM_H_POL;
    localparam logic        VP    = SIM_V_POL;

    typedef struct packed {
        logic          hs;
        logic          vs;
        logic          de;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          ls;
        logic          fs;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
`ifdef VGA_TIMING_PIX_CE_EN
    logic          pix_ce = 1'b1;
`endif
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;

    int total = 0;
    int bad   = 0;

    obs_t        exp_q[$];
    obs_t        held;
    int unsigned pos = 0;
    logic [CW-1:0] prev_x = '0;
    logic [CW-1:0] prev_y = '0;

    vga_timing_gen #(
        .CW       (CW),
        .H_ACTIVE (HA),
        .H_FRONT  (HF),
        .H_SYNC   (HS),
        .H_BACK   (HB),
        .V_ACTIVE (VA),
        .V_FRONT  (VF),
        .V_SYNC   (VS),
        .V_BACK   (VB),
        .H_POL    (HP),
        .V_POL    (VP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef VGA_TIMING_PIX_CE_EN
        .pix_ce      (pix_ce),
`endif
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .x           (x),
        .y           (y),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    function automatic obs_t reset_obs();
        obs_t o;
        o.hs = ~HP;
        o.vs = ~VP;
        o.de = 1'b0;
        o.x  = '0;
        o.y  = '0;
        o.ls = 1'b0;
        o.fs = 1'b0;
        return o;
    endfunction

    // What the raster looks like at pixel index p of the frame
    function automatic obs_t pixel_obs(input int unsigned p);
        obs_t o;
        int unsigned px;
        int unsigned py;
        px   = p % HT;
        py   = p / HT;
        o.x  = CW'(px);
        o.y  = CW'(py);
        o.de = (px < HA) && (py < VA);
        o.hs = (px >= HA + HF && px < HA + HF + HS) ? HP : ~HP;
        o.vs = (py >= VA + VF && py < VA + VF + VS) ? VP : ~VP;
        o.ls = (px == 0);
        o.fs = (px == 0) && (py == 0);
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.hs = hsync;
        o.vs = vsync;
        o.de = de;
        o.x  = x;
        o.y  = y;
        o.ls = line_start;
        o.fs = frame_start;
        return o;
    endfunction

    // Reference model: one expected observation per clock edge
    always @(posedge clk) begin
        logic ce;
        ce = 1'b1;
`ifdef VGA_TIMING_PIX_CE_EN
        ce = pix_ce;
`endif
        if (rst) begin
            held = reset_obs();
            pos  = 0;
        end else if (ce) begin
            held = pixel_obs(pos);
            pos  = (pos + 1) % FRAME;
        end else begin
            held.ls = 1'b0;
            held.fs = 1'b0;
        end
        exp_q.push_back(held);
    end

    // Monitor: compare DUT against the oldest expectation, away from the edge
    always @(posedge clk) begin
        obs_t e;
        obs_t a;
        #2;
        a = dut_obs();
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty t=%0t no expectation queued", $time);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                bad++;
                $display("FAIL raster t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b want hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b",
                         $time, a.hs, a.vs, a.de, a.x, a.y, a.ls, a.fs,
                         e.hs, e.vs, e.de, e.x, e.y, e.ls, e.fs);
            end
        end
        // y may only move together with x returning to 0
        if (!rst && y !== prev_y) begin
            total++;
            if (x !== '0) begin
                bad++;
                $display("FAIL y_step t=%0t y %0d->%0d while x=%0d (want x=0)",
                         $time, prev_y, y, x);
            end
        end
        prev_x = x;
        prev_y = y;
    end

    // Assert reset between clock edges and check the outputs respond at once
    task automatic do_reset(input int unsigned n);
        obs_t a;
        obs_t r;
        @(negedge clk);
        rst = 1'b1;
        #1;
        a = dut_obs();
        r = reset_obs();
        total++;
        if (a !== r) begin
            bad++;
            $display("FAIL reset_immediate t=%0t got hs=%b vs=%b de=%b x=%0d y=%0d ls=%b fs=%b want hs=%b vs=%b de=0 x=0 y=0 ls=0 fs=0",
                     $time, a.hs, a.vs, a.de, a.x, a.y, a.ls, a.fs, r.hs, r.vs);
        end
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset(3);

        // Clean run over several whole frames
        repeat (3 * FRAME) @(negedge clk);

`ifdef VGA_TIMING_PIX_CE_EN
        // Pixel rate of clk/4 for two frames
        for (int k = 0; k < int'(8 * FRAME); k++) begin
            @(negedge clk);
            pix_ce = (k % 4 == 3);
        end
`endif

        // Random reset points and, when available, random pixel enables
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(2 * FRAME, 3)) begin
                @(negedge clk);
`ifdef VGA_TIMING_PIX_CE_EN
                pix_ce = ($urandom_range(3, 0) != 0);
`endif
            end
            do_reset($urandom_range(3, 1));
        end

`ifdef VGA_TIMING_PIX_CE_EN
        @(negedge clk);
        pix_ce = 1'b1;
`endif
        repeat (2 * FRAME) @(negedge clk);
        @(posedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
